img_filter_mixer: RTL and testbench
===================================

Name: img_filter_mixer

Overview:
Parametrised successor to the fixed-window filter selector in the camera/VGA path. It maps the VGA raster onto a configurable, scaled filter window and selects among NUM_FILTERS filter outputs, which arrive on one flattened bus. Filter changes are applied only at frame boundaries and are crossfaded over FADE_FRAMES frames. Output is registered, with fixed latency. It sits between the VGA timing generator / filter bank and the RGB565 output stage.

Parameters:
IMG_WIDTH, 160, filter window width in source pixels.
IMG_HEIGHT, 120, filter window height in source pixels.
WIN_X0, 320, window left edge in screen pixels.
WIN_Y0, 240, window top edge in screen pixels.
SCALE_SHIFT, 1, log2 of the screen-to-source upscale factor.
NUM_FILTERS, 9, number of filter_rgb slots; slot k serves filter_sel==k.
SEL_W, 4, width of filter_sel.
FADE_FRAMES, 4, crossfade length in frames; must be one of 1, 2, 4, 8 or 16.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
filter_sel  in  SEL_W  requested filter.
DE  in  1  VGA display enable.
x_pixel  in  10  screen x.
y_pixel  in  10  screen y.
rgb565_in  in  16  camera pixel.
filter_rgb  in  16*NUM_FILTERS  filter outputs; slot k is bits [16k+15:16k].
local_x  out  10  source x in the window (combinational).
local_y  out  10  source y in the window (combinational).
filter_en  out  1  DE && in_window (combinational).
rgb565_out  out  16  mixed pixel (registered).
active_sel  out  SEL_W  currently committed filter.
busy  out  1  high while a change is armed or a fade is in progress.

Behaviour:
- Window test:
  - in_window = x in [WIN_X0, WIN_X0+(IMG_WIDTH<<SCALE_SHIFT)) and y in [WIN_Y0, WIN_Y0+(IMG_HEIGHT<<SCALE_SHIFT)).
  - local_x = (x-WIN_X0)>>SCALE_SHIFT; local_y likewise.
  - local_x, local_y and filter_en are all 0 outside the window.
- Slot resolution: a sel value s >= NUM_FILTERS, or s < 2, resolves to passthrough (rgb565_in).
- Frame boundary (fb): the cycle where DE && x_pixel==0 && y_pixel==0.
- STEP = 16/FADE_FRAMES. alpha is 5 bits, range 0..16.
- State machine:
  - IDLE: alpha=16. If filter_sel!=active_sel, go to ARMED.
  - ARMED:
    - If filter_sel returns to active_sel before fb, go back to IDLE with no change.
    - On fb, commit: prev_sel<=active_sel, active_sel<=filter_sel (sampled that cycle), alpha<=STEP. Next state is IDLE if STEP==16, else FADE.
  - FADE: on each fb, alpha+=STEP. When alpha reaches 16, go to IDLE; if filter_sel!=active_sel at that point, go to ARMED instead.
  - filter_sel changes during FADE are not committed until the fade completes. The last value held wins.
- busy = (state != IDLE).
- Blend, computed per channel on R5/G6/B5 fields:
  - out = (p*(16-alpha) + c*alpha) >> 4, truncated.
  - p = pixel for prev_sel, c = pixel for active_sel.
  - Intermediate width is channel width + 5.
  - alpha=16 yields c exactly.
- Pipeline:
  - Stage 1 registers p, c, rgb565_in, filter_en and alpha.
  - Stage 2 registers the blend result, or delayed rgb565_in when delayed filter_en==0.
  - Latency is 2 clk from inputs to rgb565_out. State changes at fb take effect on that pixel's output.
- Reset: rgb565_out=0, active_sel=0, prev_sel=0, alpha=16, state=IDLE, busy=0, and pipeline registers cleared. Reset mid-fade abandons the fade.

Optional Feature:
- FILTER_BORDER_EN defined:
  - Screen pixels on the window's outermost row/column (1 screen pixel wide) output 16'hFFE0 (yellow) while busy=1.
  - Otherwise they follow normal blending. Same 2-cycle latency.
- Not defined: no border logic; border pixels are blended normally.

Decomposition:
- Package img_filter_pkg: RGB565 field widths, alpha width (5) and ALPHA_ONE=16, state enum {IDLE, ARMED, FADE}, and a function extracting slot k from the flattened bus.
- Sub-module rgb565_blend: the combinational per-channel alpha blend, instantiated once in stage 2.

Test Plan:
- Reset, then pixel (x=400,y=300,DE=1), slot4=16'h1234, sel=4 held (IDLE→ARMED, commit at next fb, FADE_FRAMES=1) → after fb, rgb565_out=16'h1234 two clk later; local_x=40, local_y=30.
- Pixel at x=319 or x=640 with DE=1 → filter_en=0, local=0, rgb565_out equals rgb565_in delayed 2 clk.
- FADE_FRAMES=4, slot2=16'h0000 active, switch to slot5=16'hFFFF → at successive fbs alpha=4,8,12,16. Frame 1 output: R=7, G=15, B=7, i.e. (31*4)>>4, (63*4)>>4, (31*4)>>4. Final frame 16'hFFFF; busy drops at the 4th fb.
- sel toggles 3→6→3 within one frame while IDLE with active=3 → no commit at fb, active_sel stays 3, busy falls.
- Change to 7 during a fade from 2→5 → fade completes, busy stays 1, 7 commits at the following fb with prev_sel=5.
- Assert reset mid-fade → next clk active_sel=0, busy=0, rgb565_out=0; sel=12 (>=NUM_FILTERS) then gives passthrough.

Source files
------------

// File: rtl/img_filter_pkg.sv
// Shared definitions for the image filter mixer: RGB565 field widths,
// alpha format, mixer state encoding and flattened filter-bus slot access.
package img_filter_pkg;

    localparam int R_W       = 5;
    localparam int G_W       = 6;
    localparam int B_W       = 5;
    localparam int ALPHA_W   = 5;
    localparam logic [ALPHA_W-1:0] ALPHA_ONE = 5'd16;

    // Largest slot count addressable by the slot helper (4-bit index)
    localparam int MAX_SLOTS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FADE  = 2'd2
    } state_t;

    // Pick 16-bit slot k out of a flattened, zero-padded filter bus
    function automatic logic [15:0] slot_pixel(input logic [16*MAX_SLOTS-1:0] bus,
                                               input logic [3:0] k);
        return bus[{k, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/img_filter_mixer_blend.sv
// Combinational per-channel RGB565 alpha blend:
// out = (p*(16-alpha) + c*alpha) >> 4 on each of the R5/G6/B5 fields.
module rgb565_blend
    import img_filter_pkg::*;
(
    input  logic [15:0]        prev_pix,
    input  logic [15:0]        cur_pix,
    input  logic [ALPHA_W-1:0] alpha,
    output logic [15:0]        mix
);

    typedef logic [R_W+4:0] r_acc_t;
    typedef logic [G_W+4:0] g_acc_t;
    typedef logic [B_W+4:0] b_acc_t;

    logic [ALPHA_W-1:0] inv_s;
    r_acc_t             r_acc_s;
    g_acc_t             g_acc_s;
    b_acc_t             b_acc_s;

    // Weighted sum per channel; channel width + 5 bits holds 63*16 without overflow
    always_comb begin
        inv_s   = ALPHA_ONE - alpha;
        r_acc_s = r_acc_t'(prev_pix[15:11]) * r_acc_t'(inv_s)
                + r_acc_t'(cur_pix[15:11])  * r_acc_t'(alpha);
        g_acc_s = g_acc_t'(prev_pix[10:5])  * g_acc_t'(inv_s)
                + g_acc_t'(cur_pix[10:5])   * g_acc_t'(alpha);
        b_acc_s = b_acc_t'(prev_pix[4:0])   * b_acc_t'(inv_s)
                + b_acc_t'(cur_pix[4:0])    * b_acc_t'(alpha);
        mix     = {R_W'(r_acc_s >> 4), G_W'(g_acc_s >> 4), B_W'(b_acc_s >> 4)};
    end

endmodule

// File: rtl/img_filter_mixer.sv
// Maps the VGA raster onto a scaled filter window, selects among the filter
// bank outputs and crossfades between filters at frame boundaries.
// Optional build macro: FILTER_BORDER_EN (yellow window border while busy).
module img_filter_mixer
    import img_filter_pkg::*;
#(
    parameter int IMG_WIDTH   = 160,
    parameter int IMG_HEIGHT  = 120,
    parameter int WIN_X0      = 320,
    parameter int WIN_Y0      = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int NUM_FILTERS = 9,
    parameter int SEL_W       = 4,
    parameter int FADE_FRAMES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        filter_sel,
    input  logic                    DE,
    input  logic [9:0]              x_pixel,
    input  logic [9:0]              y_pixel,
    input  logic [15:0]             rgb565_in,
    input  logic [16*NUM_FILTERS-1:0] filter_rgb,
    output logic [9:0]              local_x,
    output logic [9:0]              local_y,
    output logic                    filter_en,
    output logic [15:0]             rgb565_out,
    output logic [SEL_W-1:0]        active_sel,
    output logic                    busy
);

    localparam logic [10:0] X_LO = 11'(WIN_X0);
    localparam logic [10:0] X_HI = 11'(WIN_X0 + (IMG_WIDTH << SCALE_SHIFT));
    localparam logic [10:0] Y_LO = 11'(WIN_Y0);
    localparam logic [10:0] Y_HI = 11'(WIN_Y0 + (IMG_HEIGHT << SCALE_SHIFT));
    localparam logic [9:0]  X_OFF = 10'(WIN_X0);
    localparam logic [9:0]  Y_OFF = 10'(WIN_Y0);
    localparam logic [ALPHA_W-1:0] STEP = ALPHA_W'(16 / FADE_FRAMES);

    logic                    in_window_s;
    logic                    fb_s;
    logic [9:0]              dx_s;
    logic [9:0]              dy_s;
    logic [16*MAX_SLOTS-1:0] bus_s;

    state_t                  state_r;
    state_t                  state_n;
    logic [SEL_W-1:0]        active_sel_r;
    logic [SEL_W-1:0]        active_sel_n;
    logic [SEL_W-1:0]        prev_sel_r;
    logic [SEL_W-1:0]        prev_sel_n;
    logic [ALPHA_W-1:0]      alpha_r;
    logic [ALPHA_W-1:0]      alpha_n;
    logic                    busy_r;

    logic [15:0]             p_pix_s;
    logic [15:0]             c_pix_s;
    logic [15:0]             p_r;
    logic [15:0]             c_r;
    logic [15:0]             in_r;
    logic                    en_r;
    logic [ALPHA_W-1:0]      alpha_pipe_r;
    logic [15:0]             mix_s;
    logic [15:0]             out_r;

`ifdef FILTER_BORDER_EN
    localparam logic [15:0] BORDER_RGB = 16'hFFE0;
    logic                    border_s;
    logic                    border_r;
`endif

    // Out-of-range and low slot numbers fall back to the camera pixel
    function automatic logic [15:0] resolve(input logic [SEL_W-1:0]        sel,
                                            input logic [16*MAX_SLOTS-1:0] bus,
                                            input logic [15:0]             thru);
        if ((int'(sel) >= NUM_FILTERS) || (int'(sel) < 2)) begin
            return thru;
        end else begin
            return slot_pixel(bus, 4'(sel));
        end
    endfunction

    // Window test, source coordinates and frame-boundary detect
    always_comb begin
        in_window_s = ({1'b0, x_pixel} >= X_LO) && ({1'b0, x_pixel} < X_HI) &&
                      ({1'b0, y_pixel} >= Y_LO) && ({1'b0, y_pixel} < Y_HI);
        dx_s        = x_pixel - X_OFF;
        dy_s        = y_pixel - Y_OFF;
        if (in_window_s) begin
            local_x = dx_s >> SCALE_SHIFT;
            local_y = dy_s >> SCALE_SHIFT;
        end else begin
            local_x = 10'd0;
            local_y = 10'd0;
        end
        filter_en = DE && in_window_s;
        fb_s      = DE && (x_pixel == 10'd0) && (y_pixel == 10'd0);
`ifdef FILTER_BORDER_EN
        border_s  = filter_en &&
                    (({1'b0, x_pixel} == X_LO) || ({1'b0, x_pixel} == (X_HI - 11'd1)) ||
                     ({1'b0, y_pixel} == Y_LO) || ({1'b0, y_pixel} == (Y_HI - 11'd1)));
`endif
    end

    // Zero-pad the filter bus to the fixed width the slot helper expects
    always_comb begin
        bus_s = '0;
        bus_s[16*NUM_FILTERS-1:0] = filter_rgb;
    end

    // Next-state logic: arm on a request, commit at a frame boundary, then fade
    always_comb begin
        state_n      = state_r;
        active_sel_n = active_sel_r;
        prev_sel_n   = prev_sel_r;
        alpha_n      = alpha_r;
        case (state_r)
            IDLE: begin
                alpha_n = ALPHA_ONE;
                if (filter_sel != active_sel_r) begin
                    state_n = ARMED;
                end else begin
                    state_n = IDLE;
                end
            end
            ARMED: begin
                if (filter_sel == active_sel_r) begin
                    state_n = IDLE;
                end else if (fb_s) begin
                    prev_sel_n   = active_sel_r;
                    active_sel_n = filter_sel;
                    alpha_n      = STEP;
                    state_n      = (STEP == ALPHA_ONE) ? IDLE : FADE;
                end else begin
                    state_n = ARMED;
                end
            end
            FADE: begin
                if (fb_s) begin
                    alpha_n = alpha_r + STEP;
                    if (alpha_n >= ALPHA_ONE) begin
                        alpha_n = ALPHA_ONE;
                        state_n = (filter_sel != active_sel_r) ? ARMED : IDLE;
                    end else begin
                        state_n = FADE;
                    end
                end else begin
                    state_n = FADE;
                end
            end
            default: begin
                state_n = IDLE;
                alpha_n = ALPHA_ONE;
            end
        endcase
    end

    // Mixer state register; reset abandons any pending change or fade
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            active_sel_r <= '0;
            prev_sel_r   <= '0;
            alpha_r      <= ALPHA_ONE;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            active_sel_r <= active_sel_n;
            prev_sel_r   <= prev_sel_n;
            alpha_r      <= alpha_n;
            busy_r       <= (state_n != IDLE);
        end
    end

    // Source pixels use next-state selects so a commit affects its own pixel
    always_comb begin
        p_pix_s = resolve(prev_sel_n, bus_s, rgb565_in);
        c_pix_s = resolve(active_sel_n, bus_s, rgb565_in);
    end

    // Stage 1: capture both source pixels, camera pixel, enable and alpha
    always_ff @(posedge clk) begin
        if (reset) begin
            p_r          <= 16'h0000;
            c_r          <= 16'h0000;
            in_r         <= 16'h0000;
            en_r         <= 1'b0;
            alpha_pipe_r <= ALPHA_ONE;
`ifdef FILTER_BORDER_EN
            border_r     <= 1'b0;
`endif
        end else begin
            p_r          <= p_pix_s;
            c_r          <= c_pix_s;
            in_r         <= rgb565_in;
            en_r         <= filter_en;
            alpha_pipe_r <= alpha_n;
`ifdef FILTER_BORDER_EN
            border_r     <= border_s && busy_r;
`endif
        end
    end

    rgb565_blend u_blend (
        .prev_pix (p_r),
        .cur_pix  (c_r),
        .alpha    (alpha_pipe_r),
        .mix      (mix_s)
    );

    // Stage 2: blended pixel inside the window, delayed camera pixel outside
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r <= 16'h0000;
`ifdef FILTER_BORDER_EN
        end else if (border_r) begin
            out_r <= BORDER_RGB;
`endif
        end else if (en_r) begin
            out_r <= mix_s;
        end else begin
            out_r <= in_r;
        end
    end

    assign rgb565_out = out_r;
    assign active_sel = active_sel_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_img_filter_mixer.sv
// Directed self-checking bench for img_filter_mixer (FADE_FRAMES=4).
module tb_img_filter_mixer;

    localparam int NF    = 9;
    localparam int SEL_W = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [SEL_W-1:0]    filter_sel;
    logic                DE;
    logic [9:0]          x_pixel;
    logic [9:0]          y_pixel;
    logic [15:0]         rgb565_in;
    logic [16*NF-1:0]    filter_rgb;
    logic [9:0]          local_x;
    logic [9:0]          local_y;
    logic                filter_en;
    logic [15:0]         rgb565_out;
    logic [SEL_W-1:0]    active_sel;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] fade_exp [4];

    always #5 clk = ~clk;

    img_filter_mixer #(.FADE_FRAMES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .filter_sel (filter_sel),
        .DE         (DE),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .rgb565_in  (rgb565_in),
        .filter_rgb (filter_rgb),
        .local_x    (local_x),
        .local_y    (local_y),
        .filter_en  (filter_en),
        .rgb565_out (rgb565_out),
        .active_sel (active_sel),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic de, input logic [9:0] x, input logic [9:0] y,
                       input logic [15:0] in);
        DE        = de;
        x_pixel   = x;
        y_pixel   = y;
        rgb565_in = in;
    endtask

    // One frame-boundary cycle, then a window pixel held long enough to reach the output
    task automatic frame(input logic [15:0] in);
        pix(1'b1, 10'd0, 10'd0, in);
        tick();
        pix(1'b1, 10'd400, 10'd300, in);
        tick();
        tick();
    endtask

    // Request a filter and let the full 4-frame fade run out
    task automatic settle(input logic [SEL_W-1:0] sel);
        filter_sel = sel;
        tick();
        for (int i = 0; i < 4; i++) begin
            frame(16'h0BAD);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fade_exp[0] = 16'h39E7;
        fade_exp[1] = 16'h7BEF;
        fade_exp[2] = 16'hBDF7;
        fade_exp[3] = 16'hFFFF;
        filter_rgb = {16'h8421, 16'h0F0F, 16'h5555, 16'hFFFF, 16'h1234,
                      16'hAAAA, 16'h0000, 16'hBEEF, 16'hDEAD};
        reset      = 1'b1;
        filter_sel = 4'd0;
        pix(1'b0, 10'd0, 10'd0, 16'h0000);
        tick();
        tick();
        check_eq("rst_out", 32'(rgb565_out), 32'h0000);
        check_eq("rst_active", 32'(active_sel), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Window mapping and passthrough for sel 0
        pix(1'b1, 10'd400, 10'd300, 16'h0BAD);
        #1;
        check_eq("local_x_400", 32'(local_x), 32'd40);
        check_eq("local_y_300", 32'(local_y), 32'd30);
        check_eq("en_400_300", 32'(filter_en), 32'd1);
        tick();
        tick();
        check_eq("pass_sel0", 32'(rgb565_out), 32'h0BAD);

        // Select slot 4: arm, commit at the next boundary, fade to 0x1234
        filter_sel = 4'd4;
        tick();
        check_eq("armed_busy", 32'(busy), 32'd1);
        check_eq("armed_active", 32'(active_sel), 32'd0);
        for (int i = 0; i < 4; i++) begin
            frame(16'h0BAD);
            check_eq("s4_active", 32'(active_sel), 32'd4);
            check_eq("s4_busy", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
        end
        check_eq("s4_out", 32'(rgb565_out), 32'h1234);

        // Window edges with slot 4 committed
        pix(1'b1, 10'd319, 10'd300, 16'h1357);
        #1;
        check_eq("en_x319", 32'(filter_en), 32'd0);
        check_eq("lx_x319", 32'(local_x), 32'd0);
        check_eq("ly_x319", 32'(local_y), 32'd0);
        tick();
        tick();
        check_eq("out_x319", 32'(rgb565_out), 32'h1357);
        pix(1'b1, 10'd640, 10'd300, 16'h2468);
        #1;
        check_eq("en_x640", 32'(filter_en), 32'd0);
        check_eq("lx_x640", 32'(local_x), 32'd0);
        tick();
        tick();
        check_eq("out_x640", 32'(rgb565_out), 32'h2468);
        pix(1'b1, 10'd320, 10'd240, 16'h1357);
        #1;
        check_eq("en_corner", 32'(filter_en), 32'd1);
        check_eq("lx_corner", 32'(local_x), 32'd0);
        check_eq("ly_corner", 32'(local_y), 32'd0);
        tick();
        tick();
        check_eq("out_corner", 32'(rgb565_out), 32'h1234);
        pix(1'b1, 10'd639, 10'd479, 16'h1357);
        #1;
        check_eq("lx_639", 32'(local_x), 32'd159);
        check_eq("ly_479", 32'(local_y), 32'd119);
        pix(1'b1, 10'd400, 10'd480, 16'h1357);
        #1;
        check_eq("en_y480", 32'(filter_en), 32'd0);
        check_eq("ly_y480", 32'(local_y), 32'd0);
        pix(1'b0, 10'd400, 10'd300, 16'h0F00);
        #1;
        check_eq("en_de0", 32'(filter_en), 32'd0);
        tick();
        tick();
        check_eq("out_de0", 32'(rgb565_out), 32'h0F00);

        // Four-frame crossfade from slot 2 (black) to slot 5 (white)
        settle(4'd2);
        check_eq("s2_active", 32'(active_sel), 32'd2);
        filter_sel = 4'd5;
        tick();
        for (int i = 0; i < 4; i++) begin
            frame(16'h0BAD);
            check_eq("fade_out", 32'(rgb565_out), 32'(fade_exp[i]));
            check_eq("fade_busy", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
        end

        // Request bounces back before a boundary: nothing commits
        settle(4'd3);
        filter_sel = 4'd6;
        tick();
        check_eq("tog_busy_hi", 32'(busy), 32'd1);
        filter_sel = 4'd3;
        tick();
        check_eq("tog_busy_lo", 32'(busy), 32'd0);
        frame(16'h0BAD);
        check_eq("tog_active", 32'(active_sel), 32'd3);
        check_eq("tog_busy_fb", 32'(busy), 32'd0);
        check_eq("tog_out", 32'(rgb565_out), 32'hAAAA);

        // New request mid-fade waits for the fade, then commits with prev=5
        settle(4'd2);
        filter_sel = 4'd5;
        tick();
        frame(16'h0BAD);
        filter_sel = 4'd7;
        frame(16'h0BAD);
        frame(16'h0BAD);
        frame(16'h0BAD);
        check_eq("chg_active5", 32'(active_sel), 32'd5);
        check_eq("chg_busy", 32'(busy), 32'd1);
        check_eq("chg_out5", 32'(rgb565_out), 32'hFFFF);
        frame(16'h0BAD);
        check_eq("chg_active7", 32'(active_sel), 32'd7);
        check_eq("chg_mix57", 32'(rgb565_out), 32'hBFBB);

        // Reset in the middle of that fade
        reset = 1'b1;
        tick();
        check_eq("mid_rst_active", 32'(active_sel), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_out", 32'(rgb565_out), 32'h0000);
        reset = 1'b0;

        // Out-of-range selection behaves as passthrough
        filter_sel = 4'd12;
        tick();
        frame(16'h2468);
        check_eq("sel12_active", 32'(active_sel), 32'd12);
        check_eq("sel12_out", 32'(rgb565_out), 32'h2468);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
